// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator parameter stack: geometry, word layouts
// and the read-source selector used by the responder-side register file.
package accel_pkg;

    localparam int ADDR_W  = 12;
    localparam int INEX_W  = 32;
    localparam int STATE_W = 18;
    localparam int POS_W   = 5;

    // InexRecur word layout, MSB first: {i, z, k, l}
    typedef struct packed {
        logic [7:0] i;
        logic [7:0] z;
        logic [7:0] k;
        logic [7:0] l;
    } inex_t;

    // State word: status bits above a 5-bit position field
    typedef struct packed {
        logic [STATE_W-POS_W-1:0] status;
        logic [POS_W-1:0]         pos;
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_SEQ,
        RD_RAN
    } rd_sel_e;

endpackage

// File: rtl/regfile_bank.sv
// Single-field storage bank: one registered read port, two write ports, read-first.
// Define PARAM_REGFILE_BYPASS_EN to forward same-cycle write data to the read port.
module regfile_bank
    import accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] waddr_a_i,
    input  logic [DATA_W-1:0] wdata_a_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] waddr_b_i,
    input  logic [DATA_W-1:0] wdata_b_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Port b is written last so it owns the entry should both ports ever collide
    always_ff @(posedge clk) begin
        if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
        if (we_b_i) mem_q[waddr_b_i] <= wdata_b_i;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
`ifdef PARAM_REGFILE_BYPASS_EN
            if (we_b_i && (waddr_b_i == raddr_i))
                rdata_d = wdata_b_i;
            else if (we_a_i && (waddr_a_i == raddr_i))
                rdata_d = wdata_a_i;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_regfile.sv
// Parameter-stack register file: paired InexRecur/state entries with scan, random
// read, append and write-back. Optional macro: PARAM_REGFILE_BYPASS_EN.
module param_regfile #(
    parameter int ADDR_W  = accel_pkg::ADDR_W,
    parameter int INEX_W  = accel_pkg::INEX_W,
    parameter int STATE_W = accel_pkg::STATE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_we,
    input  logic [INEX_W-1:0]  init_inex,
    input  logic [STATE_W-1:0] init_state,
    input  logic               re_seq,
    input  logic               re_ran,
    input  logic [ADDR_W-1:0]  r_addr,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [INEX_W-1:0]  inex_o,
    output logic [STATE_W-1:0] state_o,
    output logic               rd_valid_o,
    output logic               seq_wrap_o,
    input  logic               seq_we_inex,
    input  logic               seq_we_state,
    input  logic [INEX_W-1:0]  seq_w_inex,
    input  logic [STATE_W-1:0] seq_w_state,
    input  logic               ran_we_inex,
    input  logic               ran_we_state,
    input  logic [ADDR_W-1:0]  ran_w_addr_inex,
    input  logic [ADDR_W-1:0]  ran_w_addr_state,
    input  logic [INEX_W-1:0]  ran_w_inex,
    input  logic [STATE_W-1:0] ran_w_state,
    output logic [ADDR_W:0]    count_o,
    output logic               full_o,
    output logic               overflow_o,
    output logic               wr_err_o
);

    import accel_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   count_t;

    count_t  count_q, count_d;
    addr_t   rd_ptr_q, rd_ptr_d;
    addr_t   addr_q, addr_d;
    logic    valid_q, valid_d;
    logic    wrap_q, wrap_d;
    logic    ovf_q, ovf_d;
    logic    err_q, err_d;

    rd_sel_e rd_sel;
    logic    full;
    logic    seq_last;
    logic    ran_in_range;
    logic    app_req, app_ok;
    logic    inex_addr_ok, state_addr_ok;
    logic    inex_rw_ok, state_rw_ok;
    addr_t   rd_addr;
    addr_t   app_addr;

    assign full          = (count_q == count_t'(DEPTH));
    assign seq_last      = ((count_t'(rd_ptr_q) + count_t'(1)) == count_q);
    assign ran_in_range  = (count_t'(r_addr) < count_q);
    assign app_req       = seq_we_inex | seq_we_state;
    assign app_ok        = !init_we && app_req && !full;
    // Bounds use the count before this cycle's append, so write-back never hits the append slot
    assign inex_addr_ok  = (count_t'(ran_w_addr_inex) < count_q);
    assign state_addr_ok = (count_t'(ran_w_addr_state) < count_q);
    assign inex_rw_ok    = !init_we && ran_we_inex && inex_addr_ok;
    assign state_rw_ok   = !init_we && ran_we_state && state_addr_ok;
    assign app_addr      = init_we ? '0 : count_q[ADDR_W-1:0];
    assign rd_addr       = (rd_sel == RD_RAN) ? r_addr : rd_ptr_q;

    always_comb begin
        rd_sel = RD_NONE;
        if (!init_we) begin
            if (re_ran)
                rd_sel = RD_RAN;
            else if (re_seq && (count_q != '0))
                rd_sel = RD_SEQ;
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        valid_d  = 1'b0;
        wrap_d   = wrap_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        if (init_we) begin
            count_d  = count_t'(1);
            rd_ptr_d = '0;
            wrap_d   = 1'b0;
            ovf_d    = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (rd_sel)
                RD_RAN: begin
                    addr_d  = r_addr;
                    valid_d = ran_in_range;
                    wrap_d  = 1'b0;
                end
                RD_SEQ: begin
                    addr_d   = rd_ptr_q;
                    valid_d  = 1'b1;
                    wrap_d   = seq_last;
                    rd_ptr_d = seq_last ? '0 : rd_ptr_q + addr_t'(1);
                end
                default: begin
                    if (re_seq) wrap_d = 1'b0;
                end
            endcase
            if (app_req) begin
                if (full) ovf_d   = 1'b1;
                else      count_d = count_q + count_t'(1);
            end
            if ((ran_we_inex && !inex_addr_ok) || (ran_we_state && !state_addr_ok))
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // The seed shares the append port: entry 0 on init, wr_ptr (== count) otherwise
    regfile_bank #(.DATA_W(INEX_W), .ADDR_W(ADDR_W)) u_inex_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .re_i      (rd_sel != RD_NONE),
        .raddr_i   (rd_addr),
        .we_a_i    (init_we | (app_ok & seq_we_inex)),
        .waddr_a_i (app_addr),
        .wdata_a_i (init_we ? init_inex : seq_w_inex),
        .we_b_i    (inex_rw_ok),
        .waddr_b_i (ran_w_addr_inex),
        .wdata_b_i (ran_w_inex),
        .rdata_o   (inex_o)
    );

    regfile_bank #(.DATA_W(STATE_W), .ADDR_W(ADDR_W)) u_state_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .re_i      (rd_sel != RD_NONE),
        .raddr_i   (rd_addr),
        .we_a_i    (init_we | (app_ok & seq_we_state)),
        .waddr_a_i (app_addr),
        .wdata_a_i (init_we ? init_state : seq_w_state),
        .we_b_i    (state_rw_ok),
        .waddr_b_i (ran_w_addr_state),
        .wdata_b_i (ran_w_state),
        .rdata_o   (state_o)
    );

    assign count_o    = count_q;
    assign full_o     = full;
    assign addr_o     = addr_q;
    assign rd_valid_o = valid_q;
    assign seq_wrap_o = wrap_q;
    assign overflow_o = ovf_q;
    assign wr_err_o   = err_q;

endmodule

// File: tb/tb_param_regfile.sv
// Directed table-driven bench for param_regfile, plus hand sequences for fill,
// overflow, re-seed, same-cycle write/read and mid-operation reset.
module tb_param_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_we = 1'b0;
    logic [31:0] init_inex = '0;
    logic [17:0] init_state = '0;
    logic        re_seq = 1'b0;
    logic        re_ran = 1'b0;
    logic [11:0] r_addr = '0;
    logic [11:0] addr_o;
    logic [31:0] inex_o;
    logic [17:0] state_o;
    logic        rd_valid_o;
    logic        seq_wrap_o;
    logic        seq_we_inex = 1'b0;
    logic        seq_we_state = 1'b0;
    logic [31:0] seq_w_inex = '0;
    logic [17:0] seq_w_state = '0;
    logic        ran_we_inex = 1'b0;
    logic        ran_we_state = 1'b0;
    logic [11:0] ran_w_addr_inex = '0;
    logic [11:0] ran_w_addr_state = '0;
    logic [31:0] ran_w_inex = '0;
    logic [17:0] ran_w_state = '0;
    logic [12:0] count_o;
    logic        full_o;
    logic        overflow_o;
    logic        wr_err_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    param_regfile dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .init_we          (init_we),
        .init_inex        (init_inex),
        .init_state       (init_state),
        .re_seq           (re_seq),
        .re_ran           (re_ran),
        .r_addr           (r_addr),
        .addr_o           (addr_o),
        .inex_o           (inex_o),
        .state_o          (state_o),
        .rd_valid_o       (rd_valid_o),
        .seq_wrap_o       (seq_wrap_o),
        .seq_we_inex      (seq_we_inex),
        .seq_we_state     (seq_we_state),
        .seq_w_inex       (seq_w_inex),
        .seq_w_state      (seq_w_state),
        .ran_we_inex      (ran_we_inex),
        .ran_we_state     (ran_we_state),
        .ran_w_addr_inex  (ran_w_addr_inex),
        .ran_w_addr_state (ran_w_addr_state),
        .ran_w_inex       (ran_w_inex),
        .ran_w_state      (ran_w_state),
        .count_o          (count_o),
        .full_o           (full_o),
        .overflow_o       (overflow_o),
        .wr_err_o         (wr_err_o)
    );

    typedef struct packed {
        logic        init_we;
        logic        re_seq;
        logic        re_ran;
        logic [11:0] r_addr;
        logic        app_i;
        logic        app_s;
        logic [31:0] app_inex;   // also the seed word when init_we is set
        logic [17:0] app_state;
        logic        rw_i;
        logic [11:0] rw_ai;
        logic [31:0] rw_inex;
        logic        rw_s;
        logic [11:0] rw_as;
        logic [17:0] rw_state;
        logic        chk_rd;
        logic [11:0] e_addr;
        logic [31:0] e_inex;
        logic [17:0] e_state;
        logic        e_valid;
        logic        e_wrap;
        logic [12:0] e_count;
        logic        e_full;
        logic        e_ovf;
        logic        e_err;
    } vec_t;

    vec_t  tbl[$];
    string names[$];

    function automatic vec_t f_idle();
        vec_t v = '0;
        return v;
    endfunction

    function automatic vec_t f_init(input logic [31:0] inex, input int st);
        vec_t v = '0;
        v.init_we = 1'b1; v.app_inex = inex; v.app_state = 18'(st);
        return v;
    endfunction

    function automatic vec_t f_seq();
        vec_t v = '0;
        v.re_seq = 1'b1;
        return v;
    endfunction

    function automatic vec_t f_ran(input int a);
        vec_t v = '0;
        v.re_ran = 1'b1; v.r_addr = 12'(a);
        return v;
    endfunction

    function automatic vec_t f_app(input logic [31:0] inex, input int st);
        vec_t v = '0;
        v.app_i = 1'b1; v.app_s = 1'b1; v.app_inex = inex; v.app_state = 18'(st);
        return v;
    endfunction

    function automatic vec_t f_rwi(input vec_t vin, input int a, input logic [31:0] d);
        vec_t v = vin;
        v.rw_i = 1'b1; v.rw_ai = 12'(a); v.rw_inex = d;
        return v;
    endfunction

    function automatic vec_t f_rws(input vec_t vin, input int a, input int d);
        vec_t v = vin;
        v.rw_s = 1'b1; v.rw_as = 12'(a); v.rw_state = 18'(d);
        return v;
    endfunction

    function automatic vec_t ex_rd(input vec_t vin, input int a, input logic [31:0] inex,
                                   input int st, input bit wrap);
        vec_t v = vin;
        v.chk_rd = 1'b1; v.e_addr = 12'(a); v.e_inex = inex; v.e_state = 18'(st);
        v.e_valid = 1'b1; v.e_wrap = wrap;
        return v;
    endfunction

    function automatic vec_t ex_st(input vec_t vin, input int cnt, input bit full,
                                   input bit ovf, input bit err);
        vec_t v = vin;
        v.e_count = 13'(cnt); v.e_full = full; v.e_ovf = ovf; v.e_err = err;
        return v;
    endfunction

    task automatic add(input vec_t v, input string n);
        tbl.push_back(v);
        names.push_back(n);
    endtask

    task automatic set_inputs(input vec_t v);
        init_we          = v.init_we;
        init_inex        = v.app_inex;
        init_state       = v.app_state;
        re_seq           = v.re_seq;
        re_ran           = v.re_ran;
        r_addr           = v.r_addr;
        seq_we_inex      = v.app_i;
        seq_we_state     = v.app_s;
        seq_w_inex       = v.app_inex;
        seq_w_state      = v.app_state;
        ran_we_inex      = v.rw_i;
        ran_w_addr_inex  = v.rw_ai;
        ran_w_inex       = v.rw_inex;
        ran_we_state     = v.rw_s;
        ran_w_addr_state = v.rw_as;
        ran_w_state      = v.rw_state;
    endtask

    task automatic check(input vec_t v, input string n);
        logic bad;
        bad = (rd_valid_o !== v.e_valid) || (count_o !== v.e_count) || (full_o !== v.e_full)
              || (overflow_o !== v.e_ovf) || (wr_err_o !== v.e_err);
        if (v.chk_rd)
            bad = bad || (addr_o !== v.e_addr) || (inex_o !== v.e_inex)
                      || (state_o !== v.e_state) || (seq_wrap_o !== v.e_wrap);
        n_vec++;
        if (bad) begin
            n_miss++;
            $display("FAIL %s: got addr=%h inex=%h state=%h vld=%b wrap=%b cnt=%0d full=%b ovf=%b err=%b | want addr=%h inex=%h state=%h vld=%b wrap=%b cnt=%0d full=%b ovf=%b err=%b (rd fields checked=%b)",
                     n, addr_o, inex_o, state_o, rd_valid_o, seq_wrap_o, count_o, full_o,
                     overflow_o, wr_err_o, v.e_addr, v.e_inex, v.e_state, v.e_valid, v.e_wrap,
                     v.e_count, v.e_full, v.e_ovf, v.e_err, v.chk_rd);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        set_inputs(v);
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string n);
        drive(v);
        check(v, n);
        set_inputs(f_idle());
    endtask

    initial begin
        vec_t v;

        // Build the directed table
        add(ex_st(f_seq(), 0, 0, 0, 0), "seq_empty");
        add(ex_st(f_init(32'h0A0B0C0D, 1), 1, 0, 0, 0), "init_seed");
        add(ex_st(ex_rd(f_seq(), 0, 32'h0A0B0C0D, 1, 1), 1, 0, 0, 0), "seq_single");
        add(ex_st(ex_rd(f_seq(), 0, 32'h0A0B0C0D, 1, 1), 1, 0, 0, 0), "seq_single_again");
        add(ex_st(f_app(32'd1, 'h11), 2, 0, 0, 0), "append1");
        add(ex_st(f_app(32'd2, 'h12), 3, 0, 0, 0), "append2");
        add(ex_st(f_app(32'd3, 'h13), 4, 0, 0, 0), "append3");
        add(ex_st(ex_rd(f_seq(), 0, 32'h0A0B0C0D, 1, 0), 4, 0, 0, 0), "scan0");
        add(ex_st(ex_rd(f_seq(), 1, 32'd1, 'h11, 0), 4, 0, 0, 0), "scan1");
        add(ex_st(ex_rd(f_seq(), 2, 32'd2, 'h12, 0), 4, 0, 0, 0), "scan2");
        add(ex_st(ex_rd(f_seq(), 3, 32'd3, 'h13, 1), 4, 0, 0, 0), "scan3_wrap");
        add(ex_st(ex_rd(f_seq(), 0, 32'h0A0B0C0D, 1, 0), 4, 0, 0, 0), "scan_after_wrap");
        v = f_seq(); v.re_ran = 1'b1; v.r_addr = 12'd2;
        add(ex_st(ex_rd(v, 2, 32'd2, 'h12, 0), 4, 0, 0, 0), "ran_beats_seq");
        add(ex_st(ex_rd(f_seq(), 1, 32'd1, 'h11, 0), 4, 0, 0, 0), "seq_ptr_held");
        add(ex_st(f_rws(f_idle(), 1, 'h3FFFF), 4, 0, 0, 0), "rw_state1");
        add(ex_st(ex_rd(f_ran(1), 1, 32'd1, 'h3FFFF, 0), 4, 0, 0, 0), "ran1_after_rw");
        add(ex_st(f_rws(f_idle(), 7, 'h2AAAA), 4, 0, 0, 1), "rw_out_of_range");
        add(ex_st(f_ran(7), 4, 0, 0, 1), "ran_out_of_range");
        add(ex_st(ex_rd(f_ran(3), 3, 32'd3, 'h13, 0), 4, 0, 0, 1), "ran3");
        add(ex_st(f_rwi(f_app(32'h44, 'h54), 0, 32'hDEAD), 5, 0, 0, 1), "append_plus_rw");
        add(ex_st(ex_rd(f_ran(0), 0, 32'hDEAD, 1, 0), 5, 0, 0, 1), "ran0_rw_inex");
        add(ex_st(ex_rd(f_ran(4), 4, 32'h44, 'h54, 0), 5, 0, 0, 1), "ran4_appended");
        v = f_app(32'h66, 0); v.app_s = 1'b0;
        add(ex_st(v, 6, 0, 0, 1), "append_inex_only");
        add(ex_st(f_rws(f_idle(), 5, 'h77), 6, 0, 0, 1), "rw_state5");
        add(ex_st(ex_rd(f_ran(5), 5, 32'h66, 'h77, 0), 6, 0, 0, 1), "ran5_split_fields");

        // Reset state
        repeat (3) @(negedge clk);
        v = ex_st(f_idle(), 0, 0, 0, 0);
        v.chk_rd = 1'b1;
        check(v, "reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], names[i]);

        // Fill the remaining 4090 entries
        for (int i = 6; i < 4096; i++) begin
            drive(f_app(32'(i), i & 'h3FFFF));
            set_inputs(f_idle());
        end
        check(ex_st(f_idle(), 4096, 1, 0, 1), "full_reached");
        apply(ex_st(f_app(32'hBAD, 'h1BAD), 4096, 1, 1, 1), "append_overflow");
        apply(ex_st(ex_rd(f_seq(), 2, 32'd2, 'h12, 0), 4096, 1, 1, 1), "seq_when_full");

        // Re-seed while other requests are also asserted
        v = f_init(32'hCAFE, 2); v.app_i = 1'b1; v.app_s = 1'b1; v.re_seq = 1'b1;
        apply(ex_st(v, 1, 0, 0, 0), "init_clears");
        apply(ex_st(ex_rd(f_seq(), 0, 32'hCAFE, 2, 1), 1, 0, 0, 0), "seq_after_reinit");
        apply(ex_st(f_rwi(f_app(32'h11, 'h21), 1, 32'h99), 2, 0, 0, 1), "rw_at_count");
        apply(ex_st(ex_rd(f_ran(1), 1, 32'h11, 'h21, 0), 2, 0, 0, 1), "rw_at_count_dropped");
`ifdef PARAM_REGFILE_BYPASS_EN
        apply(ex_st(ex_rd(f_rwi(f_ran(1), 1, 32'h55), 1, 32'h55, 'h21, 0), 2, 0, 0, 1), "same_cycle_rw_read");
`else
        apply(ex_st(ex_rd(f_rwi(f_ran(1), 1, 32'h55), 1, 32'h11, 'h21, 0), 2, 0, 0, 1), "same_cycle_rw_read");
`endif
        apply(ex_st(ex_rd(f_ran(1), 1, 32'h55, 'h21, 0), 2, 0, 0, 1), "ran1_new_value");

        // Asynchronous reset in the middle of an append
        @(negedge clk);
        set_inputs(f_app(32'h123, 'h45));
        #2 rst_n = 1'b0;
        #1;
        v = ex_st(f_idle(), 0, 0, 0, 0);
        v.chk_rd = 1'b1;
        check(v, "async_reset_midop");
        set_inputs(f_idle());
        @(negedge clk);
        rst_n = 1'b1;
        apply(ex_st(f_seq(), 0, 0, 0, 0), "after_reset_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
